// File: rtl/dram_word_cache.sv
// Direct-mapped, write-through, one-word-per-line read cache between the CPU
// local bus and dram_bridge; the valid array is cleared by a multi-cycle flush walk.
module dram_word_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 32,
  parameter int LINES_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_read_enable,
  input  logic                  cpu_write_enable,
  input  logic [WIDTH-1:0]      cpu_write_data,
  output logic [WIDTH-1:0]      cpu_read_data,
  output logic                  cpu_wait,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_enable,
  output logic                  mem_write_enable,
  output logic [WIDTH-1:0]      mem_write_data,
  input  logic [WIDTH-1:0]      mem_read_data,
  input  logic                  mem_wait,
  input  logic                  cache_flush,
  output logic                  flush_busy
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = ADDR_WIDTH - 2 - LINES_LOG2;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, RESP, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [WIDTH-1:0]        resp_q, resp_d;
  logic                    pend_q, pend_d;
  logic [LINES_LOG2-1:0]   fcnt_q, fcnt_d;

  logic [TAG_W-1:0]        tag_ram  [LINES];
  logic [WIDTH-1:0]        data_ram [LINES];

  logic [LINES_LOG2-1:0]   cpu_idx, lat_idx;
  logic [TAG_W-1:0]        cpu_tag, lat_tag;
  logic                    cpu_hit, lat_hit, cpu_req;
  logic                    ram_we;
  logic [WIDTH-1:0]        ram_data;

  assign cpu_idx = cpu_addr[2 +: LINES_LOG2];
  assign cpu_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lat_idx = addr_q[2 +: LINES_LOG2];
  assign lat_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign cpu_hit = valid_q[cpu_idx] && (tag_ram[cpu_idx] == cpu_tag);
  assign lat_hit = valid_q[lat_idx] && (tag_ram[lat_idx] == lat_tag);
  assign cpu_req = cpu_read_enable | cpu_write_enable;

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign flush_busy     = pend_q | (state_q == FLUSH);

  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_d           = resp_q;
    pend_d           = pend_q;
    fcnt_d           = fcnt_q;
    cpu_wait         = 1'b0;
    cpu_read_data    = resp_q;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    ram_we           = 1'b0;
    ram_data         = mem_read_data;
    case (state_q)
      IDLE: begin
        if (pend_q || cache_flush) begin
          state_d  = FLUSH;
          fcnt_d   = '0;
          pend_d   = 1'b0;
          cpu_wait = cpu_req;
        end else if (cpu_write_enable) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_write_data;
          cpu_wait = 1'b1;
          state_d  = WRITE;
        end else if (cpu_read_enable && cpu_hit) begin
          cpu_read_data = data_ram[cpu_idx];
        end else if (cpu_read_enable) begin
          addr_d   = cpu_addr;
          cpu_wait = 1'b1;
          state_d  = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        mem_read_enable = 1'b1;
        cpu_wait        = 1'b1;
        pend_d          = pend_q | cache_flush;
        if (!mem_wait) begin
          ram_we           = 1'b1;
          valid_d[lat_idx] = 1'b1;
          resp_d           = mem_read_data;
          state_d          = RESP;
        end else begin
          state_d = FILL;
        end
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        cpu_wait         = 1'b1;
        pend_d           = pend_q | cache_flush;
        ram_data         = wdata_q;
        if (!mem_wait) begin
          // Write-update only: a write miss never allocates a line.
          ram_we  = lat_hit;
          state_d = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      RESP: begin
        pend_d  = pend_q | cache_flush;
        state_d = IDLE;
      end
      FLUSH: begin
        cpu_wait        = cpu_req;
        valid_d[fcnt_q] = 1'b0;
        if (cache_flush) begin
          fcnt_d = '0;
        end else if (fcnt_q == LINES_LOG2'(LINES - 1)) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q + LINES_LOG2'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and latched request; reset drops mem enables immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      tag_ram[lat_idx]  <= lat_tag;
      data_ram[lat_idx] <= ram_data;
    end
  end

endmodule

// File: tb/tb_dram_word_cache.sv
// Scenario bench for dram_word_cache: a latency-programmable memory model
// records bus transfers, which are checked against queued expectations.
module tb_dram_word_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_read_enable = 1'b0;
  logic        cpu_write_enable = 1'b0;
  logic [31:0] cpu_write_data = 32'h0;
  logic [31:0] cpu_read_data;
  logic        cpu_wait;
  logic [31:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;
  logic        mem_wait;
  logic        cache_flush = 1'b0;
  logic        flush_busy;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        act_mem_q[$];
  txn_t        exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat = 0;
  int          busy_cnt = 0;

  dram_word_cache dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr),
    .cpu_read_enable(cpu_read_enable), .cpu_write_enable(cpu_write_enable),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_wait(cpu_wait), .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_wait(mem_wait),
    .cache_flush(cache_flush), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  assign mem_wait = (mem_read_enable | mem_write_enable) && (busy_cnt < mem_lat);

  // Memory model: stall mem_lat cycles per transfer, then log the completed transfer.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (mem_read_enable | mem_write_enable) begin
      busy_cnt <= mem_wait ? busy_cnt + 1 : 0;
      if (!mem_wait) act_mem_q.push_back('{mem_write_enable, mem_addr, mem_write_data});
    end else begin
      busy_cnt <= 0;
    end
  end

  // Drives one CPU access from posedge+1 and counts stalled cycles; waits=-1 on timeout.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output int waits, output logic [31:0] rd);
    cpu_addr = addr;
    cpu_write_data = wd;
    cpu_write_enable = we;
    cpu_read_enable = ~we;
    waits = 0;
    rd = 32'h0;
    forever begin
      @(negedge clk);
      if (!cpu_wait) begin
        rd = cpu_read_data;
        break;
      end
      waits++;
      if (waits > 300) begin
        waits = -1;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_read_enable = 1'b0;
    cpu_write_enable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_wait, mem_read_enable, mem_write_enable, flush_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {cpu_wait, mem_read_enable, mem_write_enable, flush_busy});
    end
    n_checks++;
    if (cpu_read_data !== 32'h0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rd=%h addr=%h want 0", cpu_read_data, mem_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss();
    int w; logic [31:0] rd; txn_t a, e;
    mem_lat = 3;
    mem_read_data = 32'hDEADBEEF;
    exp_mem_q.push_back('{1'b0, 32'h100, 32'h0});
    exp_rd_q.push_back(32'hDEADBEEF);
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    n_checks++;
    if (w !== 5) begin n_fail++; $display("FAIL miss_latency: got %0d want 5", w); end
    e = exp_mem_q.pop_front();
    n_checks++;
    if (act_mem_q.size() != 1) begin
      n_fail++; $display("FAIL miss_txn_count: got %0d want 1", act_mem_q.size());
    end else begin
      a = act_mem_q.pop_front();
      n_checks++;
      if (a.we !== e.we || a.addr !== e.addr) begin
        n_fail++; $display("FAIL miss_txn: got we=%b addr=%h want we=%b addr=%h", a.we, a.addr, e.we, e.addr);
      end
    end
    e.data = exp_rd_q.pop_front();
    n_checks++;
    if (rd !== e.data) begin n_fail++; $display("FAIL miss_data: got %h want %h", rd, e.data); end
  endtask

  task automatic test_read_hit();
    int w; logic [31:0] rd, e;
    mem_read_data = 32'h0BAD0BAD;
    exp_rd_q.push_back(32'hDEADBEEF);
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    e = exp_rd_q.pop_front();
    n_checks++;
    if (w !== 0 || rd !== e) begin
      n_fail++; $display("FAIL hit: got waits=%0d data=%h want 0 %h", w, rd, e);
    end
    n_checks++;
    if (act_mem_q.size() != 0) begin
      n_fail++; $display("FAIL hit_no_mem: got %0d transfers want 0", act_mem_q.size());
      act_mem_q.delete();
    end
  endtask

  task automatic test_write_update();
    int w; logic [31:0] rd; txn_t a, e;
    mem_lat = 1;
    exp_mem_q.push_back('{1'b1, 32'h100, 32'h12345678});
    cpu_access(1'b1, 32'h100, 32'h12345678, w, rd);
    n_checks++;
    if (w !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", w); end
    e = exp_mem_q.pop_front();
    n_checks++;
    if (act_mem_q.size() != 1) begin
      n_fail++; $display("FAIL write_txn_count: got %0d want 1", act_mem_q.size());
      act_mem_q.delete();
    end else begin
      a = act_mem_q.pop_front();
      n_checks++;
      if (a.we !== e.we || a.addr !== e.addr || a.data !== e.data) begin
        n_fail++; $display("FAIL write_txn: got %b %h %h want %b %h %h", a.we, a.addr, a.data, e.we, e.addr, e.data);
      end
    end
    exp_rd_q.push_back(32'h12345678);
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    e.data = exp_rd_q.pop_front();
    n_checks++;
    if (w !== 0 || rd !== e.data || act_mem_q.size() != 0) begin
      n_fail++; $display("FAIL write_then_hit: got waits=%0d data=%h xfers=%0d want 0 %h 0", w, rd, act_mem_q.size(), e.data);
      act_mem_q.delete();
    end
  endtask

  task automatic test_evict();
    logic [31:0] addrs [3] = '{32'h200, 32'h100, 32'h200};
    logic [31:0] datas [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    int w; logic [31:0] rd, e; txn_t a;
    mem_lat = 0;
    for (int i = 0; i < 3; i++) begin
      mem_read_data = datas[i];
      exp_rd_q.push_back(datas[i]);
      cpu_access(1'b0, addrs[i], 32'h0, w, rd);
      e = exp_rd_q.pop_front();
      n_checks++;
      if (w !== 2 || rd !== e) begin
        n_fail++; $display("FAIL evict_%0d: got waits=%0d data=%h want 2 %h", i, w, rd, e);
      end
      n_checks++;
      if (act_mem_q.size() != 1) begin
        n_fail++; $display("FAIL evict_txn_%0d: got %0d transfers want 1", i, act_mem_q.size());
        act_mem_q.delete();
      end else begin
        a = act_mem_q.pop_front();
        if (a.addr !== addrs[i] || a.we !== 1'b0) begin
          n_fail++; $display("FAIL evict_addr_%0d: got %h want %h", i, a.addr, addrs[i]);
        end
      end
    end
  endtask

  task automatic test_flush_during_fill();
    int w, busy; logic [31:0] rd;
    mem_lat = 0;
    mem_read_data = 32'h11110100;
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    act_mem_q.delete();
    mem_lat = 3;
    mem_read_data = 32'h22220104;
    exp_rd_q.push_back(32'h22220104);
    fork
      cpu_access(1'b0, 32'h104, 32'h0, w, rd);
      begin
        @(posedge clk); #1 cache_flush = 1'b1;
        @(posedge clk); #1 cache_flush = 1'b0;
      end
    join
    n_checks++;
    if (w !== 5 || rd !== exp_rd_q.pop_front()) begin
      n_fail++; $display("FAIL flush_fill_resp: got waits=%0d data=%h want 5 22220104", w, rd);
    end
    act_mem_q.delete();
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      busy++;
    end
    n_checks++;
    if (busy !== 65) begin n_fail++; $display("FAIL flush_busy_len: got %0d want 65", busy); end
    @(posedge clk); #1;
    mem_lat = 0;
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    n_checks++;
    if (w !== 2 || act_mem_q.size() != 1) begin
      n_fail++; $display("FAIL flush_then_miss: got waits=%0d xfers=%0d want 2 1", w, act_mem_q.size());
    end
    act_mem_q.delete();
  endtask

  task automatic test_flush_restart();
    int busy;
    cache_flush = 1'b1;
    @(posedge clk); #1 cache_flush = 1'b0;
    repeat (10) @(posedge clk);
    #1 cache_flush = 1'b1;
    @(posedge clk); #1 cache_flush = 1'b0;
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      busy++;
    end
    n_checks++;
    if (busy !== 64) begin n_fail++; $display("FAIL flush_restart_len: got %0d want 64", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    int w; logic [31:0] rd;
    mem_lat = 0;
    mem_read_data = 32'h33330100;
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    n_checks++;
    if (w !== 0) begin n_fail++; $display("FAIL pre_reset_hit: got waits=%0d want 0", w); end
    act_mem_q.delete();
    mem_lat = 3;
    cpu_addr = 32'h300;
    cpu_read_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_read_enable !== 1'b0) begin
      n_fail++; $display("FAIL reset_drop_enable: got %b want 0", mem_read_enable);
    end
    cpu_read_enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n_checks++;
    if (act_mem_q.size() != 0) begin
      n_fail++; $display("FAIL reset_abandon: got %0d transfers want 0", act_mem_q.size());
      act_mem_q.delete();
    end
    mem_lat = 0;
    cpu_access(1'b0, 32'h100, 32'h0, w, rd);
    n_checks++;
    if (w !== 2 || act_mem_q.size() != 1 || rd !== 32'h33330100) begin
      n_fail++; $display("FAIL reset_then_miss: got waits=%0d xfers=%0d data=%h want 2 1 33330100", w, act_mem_q.size(), rd);
    end
    act_mem_q.delete();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_update();
    test_evict();
    test_flush_during_fill();
    test_flush_restart();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
